// File: rtl/div64_seq.sv
// Sequential unsigned radix-2 restoring divider, one quotient bit per clock.
// Ports: clk, rst_n (sync, active-low); operand handshake in_valid/in_ready
//        with dividend M and divisor N; result handshake out_valid/out_ready
//        with quotient Q, remainder R and divide-by-zero flag dbz.
module div64_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] M,
    input  logic [WIDTH-1:0] N,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             dbz
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state_q, state_d;

    // dvd holds the dividend and collects quotient bits from the LSB up
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dbz_q, dbz_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    // Shifted partial remainder kept one bit wider so the compare against
    // a divisor with its top bit set cannot overflow.
    logic [WIDTH:0]   ext;
    logic             ge;
    logic [WIDTH-1:0] sub;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] dvd_nx;

    always_comb begin
        ext    = {rem_q, dvd_q[WIDTH-1]};
        ge     = (ext >= {1'b0, dvs_q});
        // Only used when ge holds, so the result fits WIDTH bits
        sub    = ext[WIDTH-1:0] - dvs_q;
        rem_nx = ge ? sub : ext[WIDTH-1:0];
        dvd_nx = {dvd_q[WIDTH-2:0], ge};
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    dvd_d   = M;
                    dvs_d   = N;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (dvs_q == '0) begin
                    // dividend register is untouched, so it still holds M
                    q_d     = '1;
                    r_d     = dvd_q;
                    dbz_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    rem_d = rem_nx;
                    dvd_d = dvd_nx;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        q_d     = dvd_nx;
                        r_d     = rem_nx;
                        dbz_d   = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            q_q         <= '0;
            r_q         <= '0;
            dbz_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            q_q         <= q_d;
            r_q         <= r_d;
            dbz_q       <= dbz_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Q         = q_q;
    assign R         = r_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_div64_seq.sv
// Self-checking bench for div64_seq: directed corner cases plus random
// operands compared against plain integer division.
module tb_div64_seq;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] M;
    logic [W-1:0] N;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         dbz;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    div64_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .M         (M),
        .N         (N),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (Q),
        .R         (R),
        .dbz       (dbz)
    );

    task automatic check(input string tag, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: exact unsigned division, zero divisor mapped to all-ones/M
    task automatic model(input logic [W-1:0] m, input logic [W-1:0] n,
                         output logic [W-1:0] eq, output logic [W-1:0] er,
                         output logic ez);
        if (n == 0) begin
            eq = '1;
            er = m;
            ez = 1'b1;
        end else begin
            eq = m / n;
            er = m % n;
            ez = 1'b0;
        end
    endtask

    // Drive one division; hold = cycles of backpressure, poke = disturb
    // operands and in_valid while busy.
    task automatic run_div(input logic [W-1:0] m, input logic [W-1:0] n,
                           input int hold, input bit poke);
        logic [W-1:0] eq, er;
        logic         ez;
        int           lat;
        bit           rdy_bad;
        model(m, n, eq, er, ez);
        check("accept_rdy", W'(in_ready), W'(1));
        M        = m;
        N        = n;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 0;
        rdy_bad  = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_bad = 1'b1;
            if (poke && lat == 10) begin
                M        = {$urandom, $urandom};
                N        = {$urandom, $urandom};
                in_valid = 1'b1;
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check("busy_rdy_low", W'(rdy_bad), W'(0));
        check("latency", W'(lat), (n == 0) ? W'(1) : W'(W));
        check("Q", Q, eq);
        check("R", R, er);
        check("dbz", W'(dbz), W'(ez));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", W'(out_valid), W'(1));
            check("hold_rdy", W'(in_ready), W'(0));
            check("hold_Q", Q, eq);
            check("hold_R", R, er);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("drop_valid", W'(out_valid), W'(0));
        check("back_rdy", W'(in_ready), W'(1));
    endtask

    initial begin
        logic [W-1:0] rm, rn;
        bit           stale;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        M         = '0;
        N         = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_rdy", W'(in_ready), W'(1));
        check("rst_valid", W'(out_valid), W'(0));
        check("rst_Q", Q, '0);
        check("rst_R", R, '0);
        check("rst_dbz", W'(dbz), W'(0));

        run_div(64'd100, 64'd7, 0, 1'b0);
        run_div('1, 64'd1, 0, 1'b0);
        run_div('1, 64'h8000_0000_0000_0000, 0, 1'b0);
        run_div(64'd5, 64'd9, 0, 1'b0);
        run_div(64'h1234, 64'd0, 0, 1'b0);
        run_div(64'd10, 64'd3, 0, 1'b0);
        run_div(64'd1000, 64'd33, 20, 1'b0);
        run_div(64'd12345, 64'd17, 0, 1'b1);
        run_div(64'd81, 64'd9, 0, 1'b0);
        run_div(64'd7, 64'd8, 0, 1'b0);

        // Reset during iteration 30
        M        = 64'd999;
        N        = 64'd4;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_rdy", W'(in_ready), W'(1));
        check("mid_rst_valid", W'(out_valid), W'(0));
        check("mid_rst_Q", Q, '0);
        check("mid_rst_R", R, '0);
        stale = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        check("no_stale", W'(stale), W'(0));
        run_div(64'd50, 64'd5, 0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            rm = {$urandom, $urandom};
            rn = {$urandom, $urandom} >> $urandom_range(0, 63);
            if (i % 8 == 7) rn = '0;
            run_div(rm, rn, $urandom_range(0, 2), 1'(i % 3 == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
